// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register-file write port
//
// Purpose: requester A (ALU results) and requester B (load results) each push
// {addr, data} writes through a valid/ready handshake into a private FIFO. A
// round-robin arbiter pops one FIFO head per cycle into a registered write port.
//
// Ports:
//   clk                    clock, all state on the rising edge
//   rst                    synchronous active-low reset
//   a_valid/a_ready        requester A handshake
//   a_addr/a_data          requester A destination register and value
//   b_valid/b_ready        requester B handshake
//   b_addr/b_data          requester B destination register and value
//   RegWrite               registered register-file write enable
//   Register_Write_Adress  registered register-file write address
//   Write_Data             registered register-file write data
//   idle                   both FIFOs empty and no write on the port

module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Register_Write_Adress,
    output logic [DATA_W-1:0] Write_Data,
    output logic              idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0]  a_mem_q [DEPTH];
    logic [PTR_W-1:0]  a_wr_q, a_rd_q;
    logic [CNT_W-1:0]  a_cnt_q;
    logic [ENT_W-1:0]  b_mem_q [DEPTH];
    logic [PTR_W-1:0]  b_wr_q, b_rd_q;
    logic [CNT_W-1:0]  b_cnt_q;

    // Set when B took the most recent grant; reset leaves it set so A wins first.
    logic              rr_last_b_q;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              a_nonempty, b_nonempty, a_full, b_full;
    logic              a_push, b_push, grant_a, grant_b;
    logic [ENT_W-1:0]  a_head, b_head, grant_head;
    logic [ADDR_W-1:0] a_head_addr, b_head_addr, grant_addr;

    assign a_nonempty  = (a_cnt_q != '0);
    assign b_nonempty  = (b_cnt_q != '0);
    assign a_full      = (a_cnt_q == CNT_W'(DEPTH));
    assign b_full      = (b_cnt_q == CNT_W'(DEPTH));

    // Ready depends only on occupancy: a full FIFO stays not-ready even while popping.
    assign a_ready     = !a_full;
    assign b_ready     = !b_full;
    assign a_push      = a_valid && !a_full;
    assign b_push      = b_valid && !b_full;

    assign a_head      = a_mem_q[a_rd_q];
    assign b_head      = b_mem_q[b_rd_q];
    assign a_head_addr = a_head[ENT_W-1:DATA_W];
    assign b_head_addr = b_head[ENT_W-1:DATA_W];

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_nonempty && b_nonempty) begin
            // Same destination: B (the older load) goes first so A's value is the one left behind.
            if ((a_head_addr == b_head_addr) && (a_head_addr != '0)) begin
                grant_b = 1'b1;
            end else if (rr_last_b_q) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else if (a_nonempty) begin
            grant_a = 1'b1;
        end else if (b_nonempty) begin
            grant_b = 1'b1;
        end
    end

    assign grant_head = grant_b ? b_head : a_head;
    assign grant_addr = grant_head[ENT_W-1:DATA_W];

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        if (a_push) a_mem_q[a_wr_q] <= {a_addr, a_data};
        if (b_push) b_mem_q[b_wr_q] <= {b_addr, b_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_wr_q      <= '0;
            a_rd_q      <= '0;
            a_cnt_q     <= '0;
            b_wr_q      <= '0;
            b_rd_q      <= '0;
            b_cnt_q     <= '0;
            rr_last_b_q <= 1'b1;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            if (a_push)  a_wr_q <= a_wr_q + 1'b1;
            if (grant_a) a_rd_q <= a_rd_q + 1'b1;
            case ({a_push, grant_a})
                2'b10:   a_cnt_q <= a_cnt_q + 1'b1;
                2'b01:   a_cnt_q <= a_cnt_q - 1'b1;
                default: a_cnt_q <= a_cnt_q;
            endcase

            if (b_push)  b_wr_q <= b_wr_q + 1'b1;
            if (grant_b) b_rd_q <= b_rd_q + 1'b1;
            case ({b_push, grant_b})
                2'b10:   b_cnt_q <= b_cnt_q + 1'b1;
                2'b01:   b_cnt_q <= b_cnt_q - 1'b1;
                default: b_cnt_q <= b_cnt_q;
            endcase

            // A write to r0 is still a grant: it pops and moves the round-robin pointer,
            // but the enable stays low.
            if (grant_a || grant_b) begin
                rr_last_b_q <= grant_b;
                we_q        <= (grant_addr != '0);
                waddr_q     <= grant_addr;
                wdata_q     <= grant_head[DATA_W-1:0];
            end else begin
                we_q        <= 1'b0;
            end
        end
    end

    assign RegWrite              = we_q;
    assign Register_Write_Adress = waddr_q;
    assign Write_Data            = wdata_q;
    assign idle                  = !a_nonempty && !b_nonempty && !we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int ENT_W  = ADDR_W + DATA_W;

    typedef logic [ENT_W-1:0] ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              a_valid = 1'b0, b_valid = 1'b0;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              RegWrite;
    logic [ADDR_W-1:0] Register_Write_Adress;
    logic [DATA_W-1:0] Write_Data;
    logic              idle;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .a_valid               (a_valid),
        .a_ready               (a_ready),
        .a_addr                (a_addr),
        .a_data                (a_data),
        .b_valid               (b_valid),
        .b_ready               (b_ready),
        .b_addr                (b_addr),
        .b_data                (b_data),
        .RegWrite              (RegWrite),
        .Register_Write_Adress (Register_Write_Adress),
        .Write_Data            (Write_Data),
        .idle                  (idle)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per requester, the last winner, and the expected port.
    ent_t              qa[$];
    ent_t              qb[$];
    bit                m_last_b;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    // Writes seen on the port, in issue order.
    ent_t              wlog[$];
    bit                a_full_seen, b_full_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input ent_t e);
        return e[ENT_W-1:DATA_W];
    endfunction

    task automatic model_edge();
        bit   push_a, push_b, take_a, take_b;
        ent_t won;
        if (!rst) begin
            qa.delete();
            qb.delete();
            m_last_b = 1'b1;
            m_we     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            return;
        end
        push_a = a_valid && (qa.size() < DEPTH);
        push_b = b_valid && (qb.size() < DEPTH);
        take_a = 1'b0;
        take_b = 1'b0;
        if (qa.size() == 0) begin
            take_b = (qb.size() != 0);
        end else if (qb.size() == 0) begin
            take_a = 1'b1;
        end else if (addr_of(qa[0]) == addr_of(qb[0]) && addr_of(qa[0]) != 0) begin
            take_b = 1'b1;
        end else begin
            // Alternate away from whoever won last.
            take_a = m_last_b;
            take_b = !m_last_b;
        end
        if (take_a || take_b) begin
            won      = take_a ? qa.pop_front() : qb.pop_front();
            m_last_b = take_b;
            m_we     = (addr_of(won) != 0);
            m_addr   = addr_of(won);
            m_data   = won[DATA_W-1:0];
        end else begin
            m_we     = 1'b0;
        end
        if (push_a) qa.push_back({a_addr, a_data});
        if (push_b) qb.push_back({b_addr, b_data});
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("a_ready", a_ready, qa.size() < DEPTH);
        check("b_ready", b_ready, qb.size() < DEPTH);
        check("RegWrite", RegWrite, m_we);
        check("wr_addr", Register_Write_Adress, m_addr);
        check("wr_data", Write_Data, m_data);
        check("idle", idle, (qa.size() == 0) && (qb.size() == 0) && !m_we);
        if (RegWrite) wlog.push_back({Register_Write_Adress, Write_Data});
        if (!a_ready) a_full_seen = 1'b1;
        if (!b_ready) b_full_seen = 1'b1;
    endtask

    task automatic clear_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        a_data  = '0;
        b_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        wlog.delete();
    endtask

    task automatic drain(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [ADDR_W-1:0] al[3];
        logic [ADDR_W-1:0] bl[3];
        ent_t              exp_order[6];
        int                ai, bi, guard;
        bit                acc_a, acc_b;

        // 1: reset held for two edges, then quiet
        clear_inputs();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("t1_idle", idle, 1'b1);
        check("t1_a_ready", a_ready, 1'b1);
        check("t1_b_ready", b_ready, 1'b1);
        check("t1_we", RegWrite, 1'b0);
        check("t1_addr", Register_Write_Adress, 0);
        check("t1_data", Write_Data, 0);

        // 2: single A write, latency and single-cycle pulse
        do_reset();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        cycle();
        check("t2_we_edge_t", RegWrite, 1'b0);
        clear_inputs();
        cycle();
        check("t2_we", RegWrite, 1'b1);
        check("t2_addr", Register_Write_Adress, 5);
        check("t2_data", Write_Data, 32'hDEADBEEF);
        cycle();
        check("t2_we_drop", RegWrite, 1'b0);
        check("t2_idle", idle, 1'b1);

        // 3: both requesters streaming, distinct addresses
        do_reset();
        al = '{5'd1, 5'd2, 5'd3};
        bl = '{5'd9, 5'd10, 5'd11};
        exp_order = '{{5'd1, 32'hA1}, {5'd9, 32'hB9}, {5'd2, 32'hA2},
                      {5'd10, 32'hBA}, {5'd3, 32'hA3}, {5'd11, 32'hBB}};
        a_full_seen = 1'b0;
        b_full_seen = 1'b0;
        ai = 0; bi = 0; guard = 0;
        while ((ai < 3 || bi < 3) && guard < 50) begin
            a_valid = (ai < 3);
            b_valid = (bi < 3);
            if (ai < 3) begin a_addr = al[ai]; a_data = 32'hA0 + 32'(al[ai]); end
            if (bi < 3) begin b_addr = bl[bi]; b_data = 32'hB0 + 32'(bl[bi]); end
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            cycle();
            if (acc_a) ai++;
            if (acc_b) bi++;
            guard++;
        end
        check("t3_accept_timeout", guard < 50, 1'b1);
        drain(8);
        check("t3_count", wlog.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_order%0d", i), (i < wlog.size()) ? wlog[i] : '0, exp_order[i]);
        check("t3_a_full_seen", a_full_seen, 1'b1);
        check("t3_b_full_seen", b_full_seen, 1'b1);

        // 4: same destination from both sides, A must land last
        do_reset();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h22;
        cycle();
        drain(6);
        check("t4_count", wlog.size(), 2);
        check("t4_first", (wlog.size() > 0) ? wlog[0] : '0, {5'd7, 32'h22});
        check("t4_r7_final", (wlog.size() > 0) ? wlog[wlog.size()-1] : '0, {5'd7, 32'h11});

        // 5: r0 write suppressed, then normal write; r0 grant still rotates
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF;
        cycle();
        a_addr = 5'd3; a_data = 32'h3;
        cycle();
        drain(5);
        check("t5_count", wlog.size(), 1);
        check("t5_write", (wlog.size() > 0) ? wlog[0] : '0, {5'd3, 32'h3});
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0;  a_data = 32'h0F;
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hC;
        cycle();
        a_addr = 5'd4;  a_data = 32'h4;
        b_addr = 5'd13; b_data = 32'hD;
        cycle();
        drain(7);
        check("t5_alt_count", wlog.size(), 3);
        check("t5_alt0", (wlog.size() > 0) ? wlog[0] : '0, {5'd12, 32'hC});
        check("t5_alt1", (wlog.size() > 1) ? wlog[1] : '0, {5'd4, 32'h4});
        check("t5_alt2", (wlog.size() > 2) ? wlog[2] : '0, {5'd13, 32'hD});

        // 6: reset in the middle of a drain discards everything
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9;
        cycle();
        a_addr = 5'd2; b_addr = 5'd10;
        cycle();
        clear_inputs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("t6_we", RegWrite, 1'b0);
        check("t6_a_ready", a_ready, 1'b1);
        check("t6_b_ready", b_ready, 1'b1);
        check("t6_idle", idle, 1'b1);
        wlog.delete();
        drain(6);
        check("t6_no_writes", wlog.size(), 0);

        // Random traffic with small address range for collisions and r0, occasional reset
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) != 0);
            a_valid = $urandom_range(0, 3) != 0;
            b_valid = $urandom_range(0, 3) != 0;
            a_addr  = ADDR_W'($urandom_range(0, 7));
            b_addr  = ADDR_W'($urandom_range(0, 7));
            a_data  = $urandom;
            b_data  = $urandom;
            cycle();
        end
        rst = 1'b1;
        drain(6);
        check("rand_idle_end", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
